vga_timing_controller: RTL and testbench
========================================

Name: vga_timing_controller

Overview:
Sequences the horizontal and vertical pixel counters of the VGA output path from a single system clock. It derives the pixel-rate tick and chains the line counter into the frame counter. It decodes hsync, vsync and the active-video window, and emits line-start and frame-start strobes. The pixel generator and the output register stage consume these outputs.

Parameters:
COUNTER_SIZE, 11, width of h_count, v_count, pixel_x and pixel_y
CLOCK_DIVIDE, 2, system clocks per pixel (legal values >= 1)
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, hsync width in pixels
H_BACK, 48, horizontal back porch in pixels
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vsync width in lines
V_BACK, 33, vertical back porch in lines
SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low, 0 = asserted high

Ports:
control_clock  input  1  system clock; all state on rising edge
control_reset_n  input  1  asynchronous active-low reset
timing_enable  input  1  1 = run, 0 = freeze all counters
pixel_tick  output  1  one-clock strobe marking each pixel advance
h_count  output  COUNTER_SIZE  current horizontal position, 0..H_TOTAL-1
v_count  output  COUNTER_SIZE  current vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity set by SYNC_ACTIVE_LOW
video_active  output  1  1 inside the visible window
pixel_x  output  COUNTER_SIZE  h_count when video_active, else 0
pixel_y  output  COUNTER_SIZE  v_count when video_active, else 0
line_start  output  1  one-clock strobe when h_count wraps to 0
frame_start  output  1  one-clock strobe when h_count and v_count both wrap to 0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_ parameters (800); V_TOTAL = sum of the four V_ parameters (525).
- Both totals must fit in COUNTER_SIZE bits; otherwise elaboration fails.
- Reset (control_reset_n low, asynchronous) sets:
  - divider, h_count and v_count to 0
  - pixel_tick, line_start and frame_start to 0
  - video_active to 0, pixel_x and pixel_y to 0
  - hsync and vsync to their inactive level (1 when SYNC_ACTIVE_LOW = 1)
- Deassertion of reset is sampled on the next rising edge; counting starts from 0.
- Divider: counts 0..CLOCK_DIVIDE-1 while timing_enable = 1.
  - Internal advance = timing_enable AND divider == CLOCK_DIVIDE-1.
  - When CLOCK_DIVIDE = 1, advance = timing_enable.
- On advance, the horizontal counter steps: if h_count == H_TOTAL-1 it goes to 0, otherwise it increments.
- On advance with h_count == H_TOTAL-1, the vertical counter steps: if v_count == V_TOTAL-1 it goes to 0, otherwise it increments.
- Decode, computed from the next counter values and registered, so every output changes on the same edge as h_count/v_count:
  - hsync asserted when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC
  - vsync asserted when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC
  - video_active = (h_count < H_VISIBLE) AND (v_count < V_VISIBLE)
- Strobes:
  - pixel_tick is registered: high for the one clock after each advance edge, i.e. aligned with the new h_count.
  - line_start is high in the same clock as pixel_tick when the new h_count is 0.
  - frame_start is high when the new h_count and v_count are both 0.
  - All strobes are exactly one clock wide regardless of CLOCK_DIVIDE.
- timing_enable = 0:
  - divider, counters, hsync, vsync, video_active, pixel_x and pixel_y all hold.
  - Strobes are 0.
  - Re-enabling resumes from the held divider value; no tick is lost or duplicated.
- Boundaries:
  - Counters never hold a value >= H_TOTAL or V_TOTAL. Any out-of-range value (upset) wraps to 0 on the next advance.
  - Reset mid-line or mid-frame returns everything to the reset state immediately, without waiting for a clock.

Test Plan:
- Reset with default parameters -> hsync = vsync = 1, video_active = 0, h_count = v_count = 0. After release, first pixel_tick occurs 2 clocks later with h_count = 1.
- Run one line -> line_start period = 1600 clocks.
  - hsync low from h_count 656 to 751: 96 pixels = 192 clocks.
  - video_active high for h_count 0..639 on line 0.
- Run one full frame -> frame_start period = 840000 clocks.
  - vsync low only for v_count 490..491.
  - v_count wraps from 524 to 0 together with h_count 799 -> 0.
- Small-parameter build (H 4/1/2/1, V 3/1/1/1, CLOCK_DIVIDE = 1, SYNC_ACTIVE_LOW = 0) -> H_TOTAL = 8, V_TOTAL = 6.
  - hsync high at h_count 5..6.
  - frame_start every 48 clocks.
  - pixel_x = 0 whenever h_count >= 4.
- Drop timing_enable for 37 clocks at h_count = 300 with divider = 1 -> all outputs frozen, no strobes. On re-enable the next tick yields h_count = 301 after exactly 1 clock.
- Assert control_reset_n low mid-clock at v_count = 200 -> outputs reach reset values before the next edge. Restart yields frame_start after 840000 clocks.

Source files
------------

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Bundles the run control and every timing output of the VGA timing
// controller so the pixel generator and output register stage can take the
// whole group as one port.
//
//   master : the timing controller (takes timing_enable, drives the rest)
//   slave  : a consumer of the timing (drives timing_enable, takes the rest)
//
//   timing_enable  1 = run, 0 = freeze all counters
//   pixel_tick     one-clock strobe on each pixel advance
//   h_count        horizontal position, 0..H_TOTAL-1
//   v_count        vertical position, 0..V_TOTAL-1
//   hsync, vsync   sync outputs, polarity chosen by the controller
//   video_active   1 inside the visible window
//   pixel_x/y      h_count/v_count inside the visible window, else 0
//   line_start     one-clock strobe when h_count wraps to 0
//   frame_start    one-clock strobe when h_count and v_count both wrap to 0
// -----------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int COUNTER_SIZE = 11
);
    logic                    timing_enable;
    logic                    pixel_tick;
    logic [COUNTER_SIZE-1:0] h_count;
    logic [COUNTER_SIZE-1:0] v_count;
    logic                    hsync;
    logic                    vsync;
    logic                    video_active;
    logic [COUNTER_SIZE-1:0] pixel_x;
    logic [COUNTER_SIZE-1:0] pixel_y;
    logic                    line_start;
    logic                    frame_start;

    modport master (
        input  timing_enable,
        output pixel_tick, h_count, v_count, hsync, vsync, video_active,
               pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        output timing_enable,
        input  pixel_tick, h_count, v_count, hsync, vsync, video_active,
               pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_controller.sv
// -----------------------------------------------------------------------------
// vga_timing_controller
// Divides the system clock down to the pixel rate, runs the horizontal
// counter, chains it into the vertical counter and decodes sync, active-video
// and line/frame strobes. All outputs are registered and change on the same
// edge as the counters.
//
//   control_clock    system clock, all state on the rising edge
//   control_reset_n  asynchronous active-low reset
//   vga              vga_timing_if.master (enable in, timing outputs out)
// -----------------------------------------------------------------------------
module vga_timing_controller #(
    parameter int COUNTER_SIZE    = 11,
    parameter int CLOCK_DIVIDE    = 2,
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic         control_clock,
    input  logic         control_reset_n,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam int CW      = COUNTER_SIZE;
    // One spare bit so window bounds equal to 2**CW still compare correctly.
    localparam int EW      = COUNTER_SIZE + 1;

    localparam logic [EW-1:0] H_LAST   = EW'(H_TOTAL - 1);
    localparam logic [EW-1:0] V_LAST   = EW'(V_TOTAL - 1);
    localparam logic [EW-1:0] H_VIS    = EW'(H_VISIBLE);
    localparam logic [EW-1:0] V_VIS    = EW'(V_VISIBLE);
    localparam logic [EW-1:0] HS_START = EW'(H_VISIBLE + H_FRONT);
    localparam logic [EW-1:0] HS_STOP  = EW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [EW-1:0] VS_START = EW'(V_VISIBLE + V_FRONT);
    localparam logic [EW-1:0] VS_STOP  = EW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    localparam longint COUNT_RANGE = longint'(1) << COUNTER_SIZE;

    generate
        if (longint'(H_TOTAL) > COUNT_RANGE || longint'(V_TOTAL) > COUNT_RANGE) begin : g_size_err
            $error("vga_timing_controller: H_TOTAL/V_TOTAL do not fit in COUNTER_SIZE bits");
        end
        if (CLOCK_DIVIDE < 1) begin : g_div_err
            $error("vga_timing_controller: CLOCK_DIVIDE must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    h_q, h_d, v_q, v_d;
    logic [CW-1:0]    px_q, px_d, py_q, py_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             tick_q, tick_d, line_q, line_d, frame_q, frame_d;

    logic             advance;
    logic             h_wrap;
    logic             hs_in, vs_in, act_in;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        advance = vga.timing_enable && (div_q == DIV_LAST);

        div_d = div_q;
        if (vga.timing_enable) begin
            // >= rather than == so an upset divider value recovers.
            div_d = (div_q >= DIV_LAST) ? '0 : div_q + 1'b1;
        end

        // >= lets an out-of-range counter wrap to 0 on the next advance.
        h_wrap = ({1'b0, h_q} >= H_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (advance) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = ({1'b0, v_q} >= V_LAST) ? '0 : v_q + 1'b1;
            end
        end

        // Decode from the next counter values so the registered outputs line
        // up with the counters they describe.
        hs_in  = ({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_STOP);
        vs_in  = ({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_STOP);
        act_in = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);

        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        active_d = active_q;
        px_d     = px_q;
        py_d     = py_q;
        if (advance) begin
            hsync_d  = hs_in ? SYNC_ON : SYNC_OFF;
            vsync_d  = vs_in ? SYNC_ON : SYNC_OFF;
            active_d = act_in;
            px_d     = act_in ? h_d : '0;
            py_d     = act_in ? v_d : '0;
        end

        // Strobes follow advance directly, so they are one clock wide for any
        // divide ratio and are 0 while frozen.
        tick_d  = advance;
        line_d  = advance && (h_d == '0);
        frame_d = line_d && (v_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= SYNC_OFF;
            vsync_q  <= SYNC_OFF;
            active_q <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            tick_q   <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            px_q     <= px_d;
            py_q     <= py_d;
            tick_q   <= tick_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign vga.pixel_tick   = tick_q;
    assign vga.h_count      = h_q;
    assign vga.v_count      = v_q;
    assign vga.hsync        = hsync_q;
    assign vga.vsync        = vsync_q;
    assign vga.video_active = active_q;
    assign vga.pixel_x      = px_q;
    assign vga.pixel_y      = py_q;
    assign vga.line_start   = line_q;
    assign vga.frame_start  = frame_q;
endmodule

// File: tb/tb_vga_timing_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_controller
// Directed bench for vga_timing_controller. One instance uses the default
// 800x525 timing with a divide-by-2 pixel clock; a second uses a tiny 8x6
// timing, divide-by-1 and active-high syncs, so a whole frame fits in a few
// dozen clocks. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_vga_timing_controller;
    localparam int CS = 11;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if #(.COUNTER_SIZE(CS)) big_if ();
    vga_timing_if #(.COUNTER_SIZE(CS)) small_if ();

    vga_timing_controller #(
        .COUNTER_SIZE(CS), .CLOCK_DIVIDE(2),
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .SYNC_ACTIVE_LOW(1)
    ) u_big (
        .control_clock  (clk),
        .control_reset_n(rst_n),
        .vga            (big_if)
    );

    vga_timing_controller #(
        .COUNTER_SIZE(CS), .CLOCK_DIVIDE(1),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(0)
    ) u_small (
        .control_clock  (clk),
        .control_reset_n(rst_n),
        .vga            (small_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advances at least one clock, then waits (bounded) for a big-timing line_start.
    task automatic wait_big_line(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (big_if.line_start !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, big_if.line_start, 1);
    endtask

    initial begin
        int hs_clk, first_hs, last_hs, act_ticks, max_act, px_bad, lines_seen;
        int frozen_bad, n;
        int hs_bad, hs_high, vs_high, act_cnt, spx_bad, frames_seen, prev_h, prev_v;
        logic s_hs, s_vs, s_act;
        logic [CS-1:0] s_py;

        rst_n = 1'b0;
        big_if.timing_enable   = 1'b1;
        small_if.timing_enable = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_h_count", big_if.h_count, 0);
        check("rst_v_count", big_if.v_count, 0);
        check("rst_hsync", big_if.hsync, 1);
        check("rst_vsync", big_if.vsync, 1);
        check("rst_video_active", big_if.video_active, 0);
        check("rst_pixel_tick", big_if.pixel_tick, 0);
        check("rst_small_hsync", small_if.hsync, 0);
        check("rst_small_vsync", small_if.vsync, 0);

        // ---------------- first tick two clocks after release ----------------
        rst_n = 1'b1;
        @(negedge clk);
        check("tick_clk1", big_if.pixel_tick, 0);
        check("h_clk1", big_if.h_count, 0);
        @(negedge clk);
        check("tick_clk2", big_if.pixel_tick, 1);
        check("h_clk2", big_if.h_count, 1);
        check("active_clk2", big_if.video_active, 1);
        check("pixel_x_clk2", big_if.pixel_x, 1);

        // ---------------- one full line (line 1) ----------------
        wait_big_line("line0");
        check("line0_h", big_if.h_count, 0);
        check("line0_v", big_if.v_count, 1);
        hs_clk = 0; first_hs = -1; last_hs = -1; act_ticks = 0; max_act = -1;
        px_bad = 0; lines_seen = 0;
        for (int i = 0; i < 1600; i++) begin
            if (big_if.line_start === 1'b1) lines_seen++;
            if (big_if.hsync === 1'b0) begin
                hs_clk++;
                if (first_hs < 0) first_hs = int'(big_if.h_count);
                last_hs = int'(big_if.h_count);
            end
            if (big_if.pixel_tick === 1'b1 && big_if.video_active === 1'b1) begin
                act_ticks++;
                max_act = int'(big_if.h_count);
            end
            if (big_if.pixel_x !== (big_if.video_active ? big_if.h_count : '0)) px_bad++;
            @(negedge clk);
        end
        check("line_period_1600", big_if.line_start, 1);
        check("line1_end_h", big_if.h_count, 0);
        check("line1_end_v", big_if.v_count, 2);
        check("line_starts_in_line", lines_seen, 1);
        check("hsync_low_clocks", hs_clk, 192);
        check("hsync_first_h", first_hs, 656);
        check("hsync_last_h", last_hs, 751);
        check("active_ticks", act_ticks, 640);
        check("active_last_h", max_act, 639);
        check("pixel_x_window", px_bad, 0);
        check("vsync_line1", big_if.vsync, 1);

        // ---------------- freeze at h_count 300, divider 1 ----------------
        n = 0;
        while (!(big_if.pixel_tick === 1'b1 && big_if.h_count == 300) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_h300", big_if.h_count, 300);
        @(negedge clk);  // divider now 1, next edge would advance
        s_hs = big_if.hsync; s_vs = big_if.vsync; s_act = big_if.video_active;
        s_py = big_if.pixel_y;
        big_if.timing_enable = 1'b0;
        frozen_bad = 0;
        repeat (37) begin
            @(negedge clk);
            if (big_if.h_count != 300 || big_if.v_count != 2) frozen_bad++;
            if (big_if.hsync !== s_hs || big_if.vsync !== s_vs) frozen_bad++;
            if (big_if.video_active !== s_act || big_if.pixel_x != 300 || big_if.pixel_y !== s_py) frozen_bad++;
            if (big_if.pixel_tick !== 1'b0 || big_if.line_start !== 1'b0 || big_if.frame_start !== 1'b0) frozen_bad++;
        end
        check("frozen_outputs", frozen_bad, 0);
        big_if.timing_enable = 1'b1;
        @(negedge clk);
        check("resume_tick", big_if.pixel_tick, 1);
        check("resume_h", big_if.h_count, 301);
        @(negedge clk);
        check("resume_no_dup_tick", big_if.pixel_tick, 0);
        @(negedge clk);
        check("resume_next_tick", big_if.pixel_tick, 1);
        check("resume_next_h", big_if.h_count, 302);

        // ---------------- asynchronous reset mid-line ----------------
        check("pre_reset_v", big_if.v_count, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_h", big_if.h_count, 0);
        check("async_v", big_if.v_count, 0);
        check("async_hsync", big_if.hsync, 1);
        check("async_active", big_if.video_active, 0);
        check("async_pixel_x", big_if.pixel_x, 0);
        check("async_tick", big_if.pixel_tick, 0);
        check("async_small_h", small_if.h_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- small build: one frame ----------------
        @(negedge clk);
        check("small_first_h", small_if.h_count, 1);
        n = 0;
        while (small_if.frame_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("small_frame_seen", small_if.frame_start, 1);
        check("small_frame_h", small_if.h_count, 0);
        check("small_frame_v", small_if.v_count, 0);
        hs_bad = 0; hs_high = 0; vs_high = 0; act_cnt = 0; spx_bad = 0; frames_seen = 0;
        prev_h = -1; prev_v = -1;
        for (int i = 0; i < 48; i++) begin
            if (small_if.frame_start === 1'b1) frames_seen++;
            if (small_if.hsync === 1'b1) hs_high++;
            if (small_if.hsync !== (small_if.h_count >= 5 && small_if.h_count <= 6)) hs_bad++;
            if (small_if.vsync === 1'b1) vs_high++;
            if (small_if.video_active === 1'b1) act_cnt++;
            if (small_if.h_count >= 4 && small_if.pixel_x != 0) spx_bad++;
            prev_h = int'(small_if.h_count);
            prev_v = int'(small_if.v_count);
            @(negedge clk);
        end
        check("small_frame_period_48", small_if.frame_start, 1);
        check("small_frames_in_window", frames_seen, 1);
        check("small_wrap_from_h", prev_h, 7);
        check("small_wrap_from_v", prev_v, 5);
        check("small_wrap_to_v", small_if.v_count, 0);
        check("small_hsync_window", hs_bad, 0);
        check("small_hsync_clocks", hs_high, 12);
        check("small_vsync_clocks", vs_high, 8);
        check("small_active_clocks", act_cnt, 12);
        check("small_pixel_x_blank", spx_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
